// File: rtl/dvd_motion_if.sv
`default_nettype none
// ============================================================================
//  Module      : dvd_motion_if
//  Description : Control/status bundle between the frame scheduler and the
//                bouncing-logo motion controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dvd_motion_if #(
    parameter int X_W = 10,
    parameter int Y_W = 10
);
    logic           frame_tick;
    logic           pause;
    logic [1:0]     speed;
    logic [X_W-1:0] logo_x;
    logic [Y_W-1:0] logo_y;
    logic [2:0]     color_idx;
    logic           bounce;
    logic           corner;
    logic [7:0]     bounce_cnt;
    logic           busy;

    modport master (
        output frame_tick, pause, speed,
        input  logo_x, logo_y, color_idx, bounce, corner, bounce_cnt, busy
    );

    modport slave (
        input  frame_tick, pause, speed,
        output logo_x, logo_y, color_idx, bounce, corner, bounce_cnt, busy
    );
endinterface
`default_nettype wire

// File: rtl/dvd_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dvd_motion_ctrl
//  Description : Per-frame motion scheduler for the bouncing-logo screensaver.
//                Each accepted frame tick runs X then Y into shadow registers
//                and publishes both at a single commit edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module dvd_motion_ctrl #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int LOGO_W  = 128,
    parameter int LOGO_H  = 64,
    parameter int X_W     = 10,
    parameter int Y_W     = 10,
    parameter int COLOR_N = 8
) (
    input wire logic    clk,
    input wire logic    rst,
    dvd_motion_if.slave bus
);
    localparam int             c_xmax_i = H_RES - LOGO_W;
    localparam int             c_ymax_i = V_RES - LOGO_H;
    localparam logic [X_W:0]   c_xmax   = (X_W+1)'(c_xmax_i);
    localparam logic [Y_W:0]   c_ymax   = (Y_W+1)'(c_ymax_i);
    localparam logic [X_W-1:0] c_x_home = X_W'(c_xmax_i / 2);
    localparam logic [Y_W-1:0] c_y_home = Y_W'(c_ymax_i / 2);
    localparam logic [2:0]     c_col_last = 3'(COLOR_N - 1);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_calc_x = 2'd1;
    localparam logic [1:0] c_calc_y = 2'd2;
    localparam logic [1:0] c_commit = 2'd3;

    logic [1:0]     r_state, w_next_state;
    logic [2:0]     r_step;
    logic           r_dir_x, r_dir_y;       // 0 = increasing, 1 = decreasing
    logic [X_W-1:0] r_nx, r_logo_x;
    logic [Y_W-1:0] r_ny, r_logo_y;
    logic           r_hit_x, r_hit_y;
    logic [2:0]     r_color;
    logic [7:0]     r_cnt;
    logic           r_bounce, r_corner;
    logic           w_busy;

    logic [X_W:0]   w_x_ext, w_x_step, w_x_sum;
    logic [Y_W:0]   w_y_ext, w_y_step, w_y_sum;
    logic [X_W-1:0] w_nx;
    logic [Y_W-1:0] w_ny;
    logic           w_hit_x, w_hit_y;

    // State register; reset discards any partially computed update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_idle;
        else     r_state <= w_next_state;
    end

    // Next-state: ticks are only honoured in IDLE, so a tick while busy is dropped.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            c_idle:   if (bus.frame_tick && !bus.pause) w_next_state = c_calc_x;
            c_calc_x: w_next_state = c_calc_y;
            c_calc_y: w_next_state = c_commit;
            default:  w_next_state = c_idle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        w_busy = (r_state != c_idle);
    end

    // X step with wall clamp; one extra bit keeps the sum from wrapping.
    always_comb begin
        w_x_ext  = {1'b0, r_logo_x};
        w_x_step = (X_W+1)'(r_step);
        w_x_sum  = w_x_ext + w_x_step;
        w_nx     = w_x_sum[X_W-1:0];
        w_hit_x  = 1'b0;
        if (!r_dir_x) begin
            if (w_x_sum >= c_xmax) begin
                w_nx    = c_xmax[X_W-1:0];
                w_hit_x = 1'b1;
            end
        end else if (w_x_ext <= w_x_step) begin
            w_nx    = '0;
            w_hit_x = 1'b1;
        end else begin
            w_nx    = r_logo_x - X_W'(r_step);
        end
    end

    // Y step, same rule as X.
    always_comb begin
        w_y_ext  = {1'b0, r_logo_y};
        w_y_step = (Y_W+1)'(r_step);
        w_y_sum  = w_y_ext + w_y_step;
        w_ny     = w_y_sum[Y_W-1:0];
        w_hit_y  = 1'b0;
        if (!r_dir_y) begin
            if (w_y_sum >= c_ymax) begin
                w_ny    = c_ymax[Y_W-1:0];
                w_hit_y = 1'b1;
            end
        end else if (w_y_ext <= w_y_step) begin
            w_ny    = '0;
            w_hit_y = 1'b1;
        end else begin
            w_ny    = r_logo_y - Y_W'(r_step);
        end
    end

    // Datapath: latch step, fill shadows, then publish everything at COMMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step   <= 3'd1;
            r_dir_x  <= 1'b0;
            r_dir_y  <= 1'b0;
            r_nx     <= '0;
            r_ny     <= '0;
            r_hit_x  <= 1'b0;
            r_hit_y  <= 1'b0;
            r_logo_x <= c_x_home;
            r_logo_y <= c_y_home;
            r_color  <= 3'd0;
            r_cnt    <= 8'd0;
            r_bounce <= 1'b0;
            r_corner <= 1'b0;
        end else begin
            r_bounce <= 1'b0;
            r_corner <= 1'b0;
            unique case (r_state)
                c_idle: begin
                    if (bus.frame_tick && !bus.pause) r_step <= {1'b0, bus.speed} + 3'd1;
                end
                c_calc_x: begin
                    r_nx    <= w_nx;
                    r_hit_x <= w_hit_x;
                    if (w_hit_x) r_dir_x <= ~r_dir_x;
                end
                c_calc_y: begin
                    r_ny    <= w_ny;
                    r_hit_y <= w_hit_y;
                    if (w_hit_y) r_dir_y <= ~r_dir_y;
                end
                default: begin
                    r_logo_x <= r_nx;
                    r_logo_y <= r_ny;
                    r_bounce <= r_hit_x | r_hit_y;
                    r_corner <= r_hit_x & r_hit_y;
                    // A corner is still one bounce frame: single colour advance.
                    if (r_hit_x | r_hit_y) begin
                        r_color <= (r_color == c_col_last) ? 3'd0 : r_color + 3'd1;
                        if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    assign bus.logo_x     = r_logo_x;
    assign bus.logo_y     = r_logo_y;
    assign bus.color_idx  = r_color;
    assign bus.bounce     = r_bounce;
    assign bus.corner     = r_corner;
    assign bus.bounce_cnt = r_cnt;
    assign bus.busy       = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_dvd_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dvd_motion_ctrl
//  Description : Scoreboard bench for dvd_motion_ctrl. Three instances with
//                different screen geometries share one stimulus stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dvd_motion_ctrl;
    typedef struct { int x; int y; bit dx; bit dy; int col; int cnt; } mdl_t;
    typedef struct { int x; int y; int col; int cnt; bit b; bit c; } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] speed = 2'd0;

    int   n_vec = 0;
    int   n_err = 0;
    mdl_t m [3];
    int   xmax [3] = '{512, 192, 8};
    int   ymax [3] = '{416, 192, 8};
    exp_t q0 [$];
    exp_t q1 [$];
    exp_t q2 [$];
    logic [2:0] pb = 3'b000;

    dvd_motion_if #(.X_W(10), .Y_W(10)) if_b ();
    dvd_motion_if #(.X_W(10), .Y_W(10)) if_s ();
    dvd_motion_if #(.X_W(10), .Y_W(10)) if_t ();

    assign if_b.frame_tick = frame_tick;
    assign if_b.pause      = pause;
    assign if_b.speed      = speed;
    assign if_s.frame_tick = frame_tick;
    assign if_s.pause      = pause;
    assign if_s.speed      = speed;
    assign if_t.frame_tick = frame_tick;
    assign if_t.pause      = pause;
    assign if_t.speed      = speed;

    dvd_motion_ctrl u_big (.clk(clk), .rst(rst), .bus(if_b));
    dvd_motion_ctrl #(.H_RES(256), .V_RES(256), .LOGO_W(64), .LOGO_H(64))
        u_small (.clk(clk), .rst(rst), .bus(if_s));
    dvd_motion_ctrl #(.H_RES(72), .V_RES(72), .LOGO_W(64), .LOGO_H(64))
        u_tiny (.clk(clk), .rst(rst), .bus(if_t));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Reference motion model.
    function automatic void mstep(inout mdl_t s, input int step, input int xm, input int ym,
                                  output exp_t e);
        bit hx = 1'b0;
        bit hy = 1'b0;
        if (!s.dx) begin
            s.x = s.x + step;
            if (s.x >= xm) begin s.x = xm; s.dx = 1'b1; hx = 1'b1; end
        end else if (s.x <= step) begin
            s.x = 0; s.dx = 1'b0; hx = 1'b1;
        end else s.x = s.x - step;
        if (!s.dy) begin
            s.y = s.y + step;
            if (s.y >= ym) begin s.y = ym; s.dy = 1'b1; hy = 1'b1; end
        end else if (s.y <= step) begin
            s.y = 0; s.dy = 1'b0; hy = 1'b1;
        end else s.y = s.y - step;
        if (hx | hy) begin
            s.col = (s.col + 1) % 8;
            if (s.cnt < 255) s.cnt = s.cnt + 1;
        end
        e = '{s.x, s.y, s.col, s.cnt, hx | hy, hx & hy};
    endfunction

    task automatic mreset();
        for (int i = 0; i < 3; i++) m[i] = '{xmax[i] / 2, ymax[i] / 2, 1'b0, 1'b0, 0, 0};
    endtask

    task automatic push_all();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            mstep(m[i], int'(speed) + 1, xmax[i], ymax[i], e);
            case (i)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pop_chk(input int id, input int x, input int y, input int col, input int cnt,
                           input bit b, input bit c);
        exp_t e;
        bit   have = 1'b0;
        case (id)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        n_vec++;
        if (!have) begin
            n_err++;
            $display("FAIL dut%0d unexpected_commit: got x=%0d y=%0d, expected no update", id, x, y);
        end else if (x != e.x || y != e.y || col != e.col || cnt != e.cnt || b != e.b || c != e.c) begin
            n_err++;
            $display("FAIL dut%0d frame: got x=%0d y=%0d col=%0d cnt=%0d b=%0d c=%0d, expected x=%0d y=%0d col=%0d cnt=%0d b=%0d c=%0d",
                     id, x, y, col, cnt, b, c, e.x, e.y, e.col, e.cnt, e.b, e.c);
        end
    endtask

    // Monitor: busy falling (outside reset) marks a freshly committed frame.
    always @(negedge clk) begin
        if (!rst && pb[0] && !if_b.busy)
            pop_chk(0, int'(if_b.logo_x), int'(if_b.logo_y), int'(if_b.color_idx),
                    int'(if_b.bounce_cnt), if_b.bounce, if_b.corner);
        if (!rst && pb[1] && !if_s.busy)
            pop_chk(1, int'(if_s.logo_x), int'(if_s.logo_y), int'(if_s.color_idx),
                    int'(if_s.bounce_cnt), if_s.bounce, if_s.corner);
        if (!rst && pb[2] && !if_t.busy)
            pop_chk(2, int'(if_t.logo_x), int'(if_t.logo_y), int'(if_t.color_idx),
                    int'(if_t.bounce_cnt), if_t.bounce, if_t.corner);
        pb <= {if_t.busy, if_s.busy, if_b.busy};
    end

    task automatic do_tick(input bit busy_chk);
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        if (!pause) push_all();
        if (busy_chk) chk("busy_e0", if_b.busy, 1);
        @(posedge clk); #1;
        if (busy_chk) chk("busy_e1", if_b.busy, 1);
        @(posedge clk); #1;
        if (busy_chk) chk("busy_e2", if_b.busy, 1);
        @(posedge clk); #1;
        if (busy_chk) chk("busy_e3", if_b.busy, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        mreset();
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        mreset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_x", if_b.logo_x, 256);
        chk("rst_y", if_b.logo_y, 208);
        chk("rst_col", if_b.color_idx, 0);
        chk("rst_cnt", if_b.bounce_cnt, 0);
        chk("rst_busy", if_b.busy, 0);
        chk("rst_small_x", if_s.logo_x, 96);
        chk("rst_tiny_y", if_t.logo_y, 4);

        // Single slow step.
        speed = 2'd0;
        do_tick(1'b1);
        chk("s0_x", if_b.logo_x, 257);
        chk("s0_y", if_b.logo_y, 209);
        chk("s0_bounce", if_b.bounce, 0);

        // Asynchronous reset while in CALC_Y.
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("arst_x", if_b.logo_x, 256);
        chk("arst_y", if_b.logo_y, 208);
        chk("arst_busy", if_b.busy, 0);
        chk("arst_bounce", if_b.bounce, 0);
        mreset();
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("arst_hold_x", if_b.logo_x, 256);
        chk("arst_hold_cnt", if_b.bounce_cnt, 0);

        // Fast run into the bottom and right walls.
        speed = 2'd3;
        for (int i = 1; i <= 64; i++) begin
            do_tick(1'b0);
            if (i == 52) begin
                chk("t52_y", if_b.logo_y, 416);
                chk("t52_bounce", if_b.bounce, 1);
                chk("t52_corner", if_b.corner, 0);
                chk("t52_col", if_b.color_idx, 1);
                @(posedge clk); #1;
                chk("t52_bounce_pulse", if_b.bounce, 0);
            end
            if (i == 53) begin
                chk("t53_y", if_b.logo_y, 412);
                chk("t53_x", if_b.logo_x, 468);
            end
            if (i == 64) begin
                chk("t64_x", if_b.logo_x, 512);
                chk("t64_bounce", if_b.bounce, 1);
                chk("t64_col", if_b.color_idx, 2);
                chk("t64_cnt", if_b.bounce_cnt, 2);
            end
        end

        // Corner hit on the 256x256 geometry.
        do_reset();
        speed = 2'd0;
        for (int i = 1; i <= 96; i++) do_tick(1'b0);
        chk("corner_x", if_s.logo_x, 192);
        chk("corner_y", if_s.logo_y, 192);
        chk("corner_bounce", if_s.bounce, 1);
        chk("corner_corner", if_s.corner, 1);
        chk("corner_col", if_s.color_idx, 1);
        chk("corner_cnt", if_s.bounce_cnt, 1);

        // Paused tick does nothing.
        pause = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        chk("pause_busy", if_b.busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("pause_x", if_b.logo_x, 352);
        chk("pause_busy_late", if_b.busy, 0);
        pause = 1'b0;

        // Back-to-back tick is dropped; mid-flight speed change is ignored.
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1;
        push_all();
        speed = 2'd2;
        @(posedge clk); #1 frame_tick = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("dbl_x", if_b.logo_x, 353);
        chk("dbl_busy", if_b.busy, 0);

        // Colour wrap and counter saturation on the tiny geometry.
        do_reset();
        speed = 2'd3;
        for (int i = 1; i <= 600; i++) begin
            do_tick(1'b0);
            if (i == 13) chk("wrap_col7", if_t.color_idx, 7);
            if (i == 15) chk("wrap_col0", if_t.color_idx, 0);
            if (i == 17) begin
                chk("wrap_col1", if_t.color_idx, 1);
                chk("wrap_cnt9", if_t.bounce_cnt, 9);
            end
        end
        chk("sat_cnt", if_t.bounce_cnt, 255);

        repeat (5) @(posedge clk);
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);
        chk("drain_q2", q2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
